// File: rtl/ahb_rsp_mux.sv
// AHB data-phase response mux with an internal default slave that answers unmapped accesses with ERROR.
// Optional error-address capture is enabled by defining AHB_RSP_ERRCAP_EN.
module ahb_rsp_mux #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic [1:0]    htrans,
  input  logic          hsel2,
  input  logic          hsel0_rd,
  input  logic          hsel1_rd,
  input  logic          hsel2_rd,
  input  logic [DW-1:0] hrdata0,
  input  logic [DW-1:0] hrdata1,
  input  logic          hreadyout0,
  input  logic          hreadyout1,
  input  logic [1:0]    hresp0,
  input  logic [1:0]    hresp1,
  input  logic          err_clr,
`ifdef AHB_RSP_ERRCAP_EN
  input  logic [31:0]   haddr,
  output logic [31:0]   err_addr,
  output logic          err_vld,
`endif
  output logic [DW-1:0] hrdata,
  output logic          hready,
  output logic [1:0]    hresp,
  output logic [CW-1:0] err_cnt
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } state_t;

  state_t        state_reg;
  logic          fsm_ready_reg;
  logic [1:0]    fsm_resp_reg;
  logic [CW-1:0] err_cnt_reg;
  logic          accept;

  // Only the transfer-type MSB distinguishes NONSEQ/SEQ from IDLE/BUSY.
  logic unused_htrans;
  assign unused_htrans = htrans[0];

  assign accept = hsel2 & hready & htrans[1];

  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = RESP_OKAY;
    if (hsel0_rd) begin
      hrdata = hrdata0;
      hready = hreadyout0;
      hresp  = hresp0;
    end else if (hsel1_rd) begin
      hrdata = hrdata1;
      hready = hreadyout1;
      hresp  = hresp1;
    end else if (hsel2_rd) begin
      hready = fsm_ready_reg;
      hresp  = fsm_resp_reg;
    end
  end

  // Default slave: two-cycle ERROR; outputs are registered alongside the state.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_reg     <= IDLE;
      fsm_ready_reg <= 1'b1;
      fsm_resp_reg  <= RESP_OKAY;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg     <= ERR1;
            fsm_ready_reg <= 1'b0;
            fsm_resp_reg  <= RESP_ERROR;
          end
        end
        ERR1: begin
          state_reg     <= ERR2;
          fsm_ready_reg <= 1'b1;
          fsm_resp_reg  <= RESP_ERROR;
        end
        ERR2: begin
          if (accept) begin
            state_reg     <= ERR1;
            fsm_ready_reg <= 1'b0;
            fsm_resp_reg  <= RESP_ERROR;
          end else begin
            state_reg     <= IDLE;
            fsm_ready_reg <= 1'b1;
            fsm_resp_reg  <= RESP_OKAY;
          end
        end
        default: begin
          state_reg     <= IDLE;
          fsm_ready_reg <= 1'b1;
          fsm_resp_reg  <= RESP_OKAY;
        end
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      err_cnt_reg <= '0;
    end else if (err_clr) begin
      err_cnt_reg <= CW'(accept);
    end else if (accept && (err_cnt_reg != {CW{1'b1}})) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign err_cnt = err_cnt_reg;

`ifdef AHB_RSP_ERRCAP_EN
  logic [31:0] err_addr_reg;
  logic        err_vld_reg;

  // Clear takes effect first so a coincident accept is captured fresh.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      err_addr_reg <= '0;
      err_vld_reg  <= 1'b0;
    end else if (err_clr) begin
      err_addr_reg <= accept ? haddr : 32'h0;
      err_vld_reg  <= accept;
    end else if (accept && !err_vld_reg) begin
      err_addr_reg <= haddr;
      err_vld_reg  <= 1'b1;
    end
  end

  assign err_addr = err_addr_reg;
  assign err_vld  = err_vld_reg;
`endif

endmodule

// File: tb/tb_ahb_rsp_mux.sv
// Testbench for ahb_rsp_mux: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_ahb_rsp_mux;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          hclk = 1'b0;
  logic          hreset;
  logic [1:0]    htrans;
  logic          hsel2;
  logic          hsel0_rd, hsel1_rd, hsel2_rd;
  logic [DW-1:0] hrdata0, hrdata1;
  logic          hreadyout0, hreadyout1;
  logic [1:0]    hresp0, hresp1;
  logic          err_clr;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic [1:0]    hresp;
  logic [CW-1:0] err_cnt;
`ifdef AHB_RSP_ERRCAP_EN
  logic [31:0]   haddr;
  logic [31:0]   err_addr;
  logic          err_vld;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: phase of the unmapped error response (0 none, 1 first cycle, 2 second cycle).
  int          m_phase = 0;
  int          m_cnt = 0;
  logic        m_vld = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [DW-1:0] exp_rdata;
  logic          exp_ready;
  logic [1:0]    exp_resp;

  always #5 hclk = ~hclk;

  ahb_rsp_mux #(.DW(DW), .CW(CW)) dut (
    .hclk(hclk), .hreset(hreset), .htrans(htrans), .hsel2(hsel2),
    .hsel0_rd(hsel0_rd), .hsel1_rd(hsel1_rd), .hsel2_rd(hsel2_rd),
    .hrdata0(hrdata0), .hrdata1(hrdata1),
    .hreadyout0(hreadyout0), .hreadyout1(hreadyout1),
    .hresp0(hresp0), .hresp1(hresp1), .err_clr(err_clr),
`ifdef AHB_RSP_ERRCAP_EN
    .haddr(haddr), .err_addr(err_addr), .err_vld(err_vld),
`endif
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .err_cnt(err_cnt)
  );

  function automatic void model_eval();
    exp_rdata = '0;
    exp_ready = 1'b1;
    exp_resp  = 2'b00;
    if (hsel0_rd) begin
      exp_rdata = hrdata0; exp_ready = hreadyout0; exp_resp = hresp0;
    end else if (hsel1_rd) begin
      exp_rdata = hrdata1; exp_ready = hreadyout1; exp_resp = hresp1;
    end else if (hsel2_rd) begin
      exp_ready = (m_phase != 1);
      exp_resp  = (m_phase == 0) ? 2'b00 : 2'b01;
    end
  endfunction

  task automatic tick();
    int np, nc;
    logic nv, acc;
    logic [31:0] na;
    model_eval();
    acc = hsel2 && exp_ready && htrans[1];
    np = m_phase; nc = m_cnt; nv = m_vld; na = m_addr;
    if (hreset) begin
      np = 0; nc = 0; nv = 1'b0; na = 32'h0;
    end else begin
      np = (m_phase == 1) ? 2 : (acc ? 1 : 0);
      if (err_clr) nc = acc ? 1 : 0;
      else if (acc) nc = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
`ifdef AHB_RSP_ERRCAP_EN
      if (err_clr) begin
        nv = acc; na = acc ? haddr : 32'h0;
      end else if (acc && !m_vld) begin
        nv = 1'b1; na = haddr;
      end
`endif
    end
    @(posedge hclk);
    m_phase = np; m_cnt = nc; m_vld = nv; m_addr = na;
    @(negedge hclk);
    #1;
  endtask

  task automatic idle_inputs();
    htrans = 2'b00; hsel2 = 1'b0;
    hsel0_rd = 1'b0; hsel1_rd = 1'b0; hsel2_rd = 1'b0;
    hrdata0 = '0; hrdata1 = '0; hreadyout0 = 1'b1; hreadyout1 = 1'b1;
    hresp0 = 2'b00; hresp1 = 2'b00; err_clr = 1'b0;
`ifdef AHB_RSP_ERRCAP_EN
    haddr = 32'h0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    hreset = 1'b1;
    tick(); tick();
    hreset = 1'b0;
    tick();
    checks++;
    if (hready !== 1'b1 || hresp !== 2'b00 || hrdata !== '0) begin
      failures++;
      $display("FAIL reset_bus got ready=%b resp=%b rdata=%h want ready=1 resp=00 rdata=0", hready, hresp, hrdata);
    end
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_cnt got %0d want 0", err_cnt);
    end
`ifdef AHB_RSP_ERRCAP_EN
    checks++;
    if (err_vld !== 1'b0 || err_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_cap got vld=%b addr=%h want 0/0", err_vld, err_addr);
    end
`endif
    $display("test_reset ready=%b resp=%b rdata=%h cnt=%0d", hready, hresp, hrdata, err_cnt);
  endtask

  task automatic test_slot0_wait();
    idle_inputs();
    hsel0_rd = 1'b1; hrdata0 = 32'hDEADBEEF; hreadyout0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (hready !== 1'b0) begin
        failures++;
        $display("FAIL slot0_wait%0d got ready=%b want 0", i, hready);
      end
      tick();
    end
    hreadyout0 = 1'b1;
    #1;
    checks++;
    if (hready !== 1'b1 || hrdata !== 32'hDEADBEEF || hresp !== 2'b00) begin
      failures++;
      $display("FAIL slot0_data got ready=%b rdata=%h resp=%b want 1/deadbeef/00", hready, hrdata, hresp);
    end
    $display("test_slot0_wait rdata=%h ready=%b resp=%b", hrdata, hready, hresp);
    tick();
    idle_inputs();
  endtask

  task automatic test_unmapped_single();
    logic [7:0] c0;
    idle_inputs();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    c0 = err_cnt;
    htrans = 2'b10; hsel2 = 1'b1;
`ifdef AHB_RSP_ERRCAP_EN
    haddr = 32'h4000_0000;
`endif
    tick();
    htrans = 2'b00; hsel2 = 1'b0; hsel2_rd = 1'b1;
    #1;
    checks++;
    if (hready !== 1'b0 || hresp !== 2'b01) begin
      failures++;
      $display("FAIL single_err1 got ready=%b resp=%b want 0/01", hready, hresp);
    end
    checks++;
    if (err_cnt !== c0 + 8'd1) begin
      failures++;
      $display("FAIL single_cnt got %0d want %0d", err_cnt, c0 + 8'd1);
    end
    tick();
    checks++;
    if (hready !== 1'b1 || hresp !== 2'b01) begin
      failures++;
      $display("FAIL single_err2 got ready=%b resp=%b want 1/01", hready, hresp);
    end
    tick();
    checks++;
    if (hready !== 1'b1 || hresp !== 2'b00) begin
      failures++;
      $display("FAIL single_idle got ready=%b resp=%b want 1/00", hready, hresp);
    end
`ifdef AHB_RSP_ERRCAP_EN
    checks++;
    if (err_vld !== 1'b1 || err_addr !== 32'h4000_0000) begin
      failures++;
      $display("FAIL single_cap got vld=%b addr=%h want 1/40000000", err_vld, err_addr);
    end
`endif
    $display("test_unmapped_single cnt=%0d", err_cnt);
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_r [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] exp_p [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    idle_inputs();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    hsel2_rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      htrans = (i < 3) ? 2'b10 : 2'b00;
      hsel2  = (i < 3);
`ifdef AHB_RSP_ERRCAP_EN
      haddr = (i == 0) ? 32'h5000_0000 : 32'h5000_0004;
`endif
      #1;
      checks++;
      if (hready !== exp_r[i] || hresp !== exp_p[i]) begin
        failures++;
        $display("FAIL b2b_cycle%0d got ready=%b resp=%b want %b/%b", i, hready, hresp, exp_r[i], exp_p[i]);
      end
      tick();
    end
    checks++;
    if (err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL b2b_cnt got %0d want 2", err_cnt);
    end
`ifdef AHB_RSP_ERRCAP_EN
    checks++;
    if (err_vld !== 1'b1 || err_addr !== 32'h5000_0000) begin
      failures++;
      $display("FAIL b2b_cap got vld=%b addr=%h want 1/50000000", err_vld, err_addr);
    end
`endif
    $display("test_back_to_back cnt=%0d", err_cnt);
    idle_inputs();
  endtask

  task automatic test_reset_in_err1();
    idle_inputs();
    htrans = 2'b10; hsel2 = 1'b1;
    tick();
    htrans = 2'b00; hsel2 = 1'b0; hsel2_rd = 1'b1;
    #1;
    checks++;
    if (hready !== 1'b0) begin
      failures++;
      $display("FAIL rst_err1_pre got ready=%b want 0", hready);
    end
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    #1;
    checks++;
    if (hready !== 1'b1 || hresp !== 2'b00 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rst_err1_post got ready=%b resp=%b cnt=%0d want 1/00/0", hready, hresp, err_cnt);
    end
    $display("test_reset_in_err1 ready=%b resp=%b cnt=%0d", hready, hresp, err_cnt);
    idle_inputs();
    tick();
  endtask

  task automatic test_saturate_and_clear();
    idle_inputs();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    htrans = 2'b11; hsel2 = 1'b1;
    for (int i = 0; i < CNT_MAX; i++) tick();
    checks++;
    if (err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_preset got %0d want 255", err_cnt);
    end
    tick();
    checks++;
    if (err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_hold got %0d want 255", err_cnt);
    end
    err_clr = 1'b1;
    tick();
    checks++;
    if (err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL clr_accept got %0d want 1", err_cnt);
    end
    htrans = 2'b00; hsel2 = 1'b0;
    tick();
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL clr_alone got %0d want 0", err_cnt);
    end
    $display("test_saturate_and_clear cnt=%0d", err_cnt);
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int s;
      htrans = 2'($urandom_range(0, 3));
      hsel2  = ($urandom_range(0, 2) != 0);
      s = $urandom_range(0, 7);
      hsel0_rd = (s == 1) || (s == 7);
      hsel1_rd = (s == 2) || (s == 6);
      hsel2_rd = (s >= 3);
      hrdata0 = $urandom; hrdata1 = $urandom;
      hreadyout0 = $urandom_range(0, 1) != 0;
      hreadyout1 = $urandom_range(0, 1) != 0;
      hresp0 = 2'($urandom_range(0, 3)); hresp1 = 2'($urandom_range(0, 3));
      err_clr = ($urandom_range(0, 19) == 0);
      hreset  = ($urandom_range(0, 49) == 0);
`ifdef AHB_RSP_ERRCAP_EN
      haddr = $urandom;
`endif
      #1;
      model_eval();
      checks++;
      if (hrdata !== exp_rdata || hready !== exp_ready || hresp !== exp_resp) begin
        failures++;
        $display("FAIL rand%0d_bus got %h/%b/%b want %h/%b/%b", n, hrdata, hready, hresp, exp_rdata, exp_ready, exp_resp);
      end
      checks++;
      if (err_cnt !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL rand%0d_cnt got %0d want %0d", n, err_cnt, m_cnt);
      end
`ifdef AHB_RSP_ERRCAP_EN
      checks++;
      if (err_vld !== m_vld || err_addr !== m_addr) begin
        failures++;
        $display("FAIL rand%0d_cap got %b/%h want %b/%h", n, err_vld, err_addr, m_vld, m_addr);
      end
`endif
      $display("rand%0d sel=%b%b%b trans=%b hsel2=%b ready=%b resp=%b cnt=%0d", n, hsel0_rd, hsel1_rd, hsel2_rd, htrans, hsel2, hready, hresp, err_cnt);
      tick();
    end
    hreset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    hreset = 1'b1;
    idle_inputs();
    @(negedge hclk);
    test_reset();
    test_slot0_wait();
    test_unmapped_single();
    test_back_to_back();
    test_reset_in_err1();
    test_saturate_and_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ahb_rsp_mux.md
# ahb_rsp_mux

AHB data-phase response stage that sits directly downstream of the address decoder. It takes the decoder's registered data-phase selects and steers HRDATA/HREADY/HRESP from slave 0, slave 1, or an internal default slave back to the master. The default slave covers slot 2, the unmapped address space, and answers every active transfer to it with a two-cycle AHB ERROR response. The block keeps a saturating count of unmapped accesses. It drives the global `hready` that the decoder uses as its `ready` input.

## Interface
Parameters:
- `DW`, 32, data width of `hrdata*`.
- `CW`, 8, width of `err_cnt`.

Ports:
- `hclk`  in  1  bus clock; all state updates on rising edge.
- `hreset`  in  1  synchronous, active-high reset.
- `htrans`  in  2  master transfer type, address phase.
- `hsel2`  in  1  decoder address-phase select for the unmapped region.
- `hsel0_rd`, `hsel1_rd`, `hsel2_rd`  in  1 each  decoder data-phase selects.
- `hrdata0`, `hrdata1`  in  DW each  slave read data.
- `hreadyout0`, `hreadyout1`  in  1 each  slave ready.
- `hresp0`, `hresp1`  in  2 each  slave response (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT).
- `err_clr`  in  1  synchronous clear of `err_cnt`.
- `hrdata`  out  DW  muxed read data.
- `hready`  out  1  muxed ready; global HREADY.
- `hresp`  out  2  muxed response.
- `err_cnt`  out  CW  number of unmapped transfers; saturates at all-ones.

## Operation

**Mux (combinational on `*_rd`)**
- Priority is `hsel0_rd` > `hsel1_rd` > `hsel2_rd`. More than one set is illegal, but priority still applies.
- Slot 0 or 1 selected: pass that slave's `hrdata`/`hreadyout`/`hresp` through unchanged.
- Slot 2 selected: drive `hrdata`=0, and take `hready`/`hresp` from the default slave FSM.
- No select set (after reset): `hrdata`=0, `hready`=1, `hresp`=OKAY.

**Default slave FSM** (states IDLE, ERR1, ERR2). An accept happens when `hsel2 & hready & htrans[1]` (NONSEQ/SEQ).
- IDLE: ready=1, resp=OKAY.
  - Accept → ERR1.
  - IDLE/BUSY transfers to slot 2 get a zero-wait OKAY and cause no transition.
- ERR1: ready=0, resp=ERROR. Unconditional → ERR2.
- ERR2: ready=1, resp=ERROR.
  - Accept (back-to-back unmapped) → ERR1.
  - Otherwise → IDLE.
- The FSM output affects bus signals only while `hsel2_rd`=1. The FSM advances regardless of `hsel2_rd`.

**err_cnt**
- +1 on every accept, saturating at 2^CW−1.
- `err_clr` alone → 0.
- `err_clr` together with an accept → 1.

## Timing
- Reset values: FSM=IDLE, `err_cnt`=0. Mux outputs then follow their inputs; with all `*_rd`=0 this gives `hrdata`=0, `hready`=1, `hresp`=00.
- ERROR latency for an unmapped transfer, counted from its address-phase accept edge:
  - cycle 1: `hready`=0, `hresp`=01.
  - cycle 2: `hready`=1, `hresp`=01.
  - The next transfer's data phase starts after cycle 2.
- Slave paths add zero cycles; the mux is purely combinational.
- `hreset` asserted in ERR1 or ERR2: IDLE at that edge. The next cycle shows ready=1/OKAY on slot 2.
- `err_cnt` updates on the edge of the accept. It is visible one cycle later.

## Configuration
- `AHB_RSP_ERRCAP_EN` defined:
  - Adds input `haddr` [31:0], and outputs `err_addr` [31:0] and `err_vld` [1].
  - On an accept while `err_vld`=0: capture `haddr` into `err_addr` and set `err_vld`=1.
  - Later accepts do not overwrite the captured address.
  - `err_clr` clears `err_vld` and `err_addr` to 0. On a simultaneous accept, clear then capture, so `err_vld`=1 holding the new `haddr`.
  - Reset: `err_vld`=0, `err_addr`=0.
- Macro not defined: these ports and registers do not exist; all other behaviour is identical.

## Test plan
- Reset, then idle: `hready`=1, `hresp`=00, `hrdata`=0, `err_cnt`=0.
- Slot 0 read, `hsel0_rd`=1, `hrdata0`=0xDEADBEEF, `hreadyout0` low for 2 cycles → `hready` low 2 cycles, then `hrdata`=0xDEADBEEF, `hresp`=00.
- Single NONSEQ to 0x40000000 → exactly one cycle `hready`=0/`hresp`=01, then one cycle `hready`=1/`hresp`=01; `err_cnt`=1. With the macro: `err_addr`=0x40000000, `err_vld`=1.
- Two back-to-back NONSEQ to 0x50000000, 0x50000004 → ERR1, ERR2, ERR1, ERR2 then IDLE; `err_cnt`=2. With the macro: `err_addr` stays 0x50000000.
- `hreset` pulsed during ERR1 → next cycle `hready`=1, `hresp`=00, `err_cnt`=0.
- `err_cnt` preset to 255 by 255 accepts, then one more accept → stays 255. `err_clr` coincident with an accept → `err_cnt`=1.
